// File: rtl/unaligner_if.sv
// unaligner_if: packed-word input stream and record output stream of the unaligner.
interface unaligner_if #(
  parameter int DATA_WIDTH = 256,
  parameter int TAG_WIDTH = 16,
  parameter int LEN_WIDTH = 8
);
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic [5:0] in_bytes;
  logic out_valid;
  logic out_ready;
  logic [TAG_WIDTH-1:0] out_tag;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LEN_WIDTH-1:0] out_len;
  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input in_ready, out_valid, out_tag, out_data, out_len
  );
  modport slave (
    input in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_tag, out_data, out_len
  );
endinterface

// File: rtl/unaligner.sv
// unaligner: splits the packed 256-bit word stream back into tag + halfword records.
// Defining UNALIGNER_STAT_EN adds a 32-bit rec_count output counting delivered records.
module unaligner #(
  parameter int DATA_WIDTH = 256,
  parameter int TAG_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  unaligner_if.slave bus,
  output logic trunc
`ifdef UNALIGNER_STAT_EN
  ,
  output logic [31:0] rec_count
`endif
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [0:0] state;
  logic [2*DATA_WIDTH-1:0] mem;
  logic [2*DATA_WIDTH-1:0] mem_d;
  logic [6:0] fill;
  logic [6:0] fill_d;
  logic [6:0] rem;
  logic [TAG_WIDTH-1:0] tag;
  logic [4:0] pc;
  logic [5:0] len;
  logic [5:0] nbytes;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] payload;
  logic ext;
  logic accept;
  logic done;
  // Buffer bytes at or above fill are kept zero, so shifting and OR-ing in a masked word is enough.
  always_comb begin
    tag = mem[TAG_WIDTH-1:0];
    pc = '0;
    for (int i = 0; i < TAG_WIDTH; i++) pc = pc + 5'(tag[i]);
    len = 6'd2 + {pc, 1'b0};
    ext = fill >= 7'd2 && fill >= {1'b0, len} && (!bus.out_valid || bus.out_ready);
    rem = fill - (ext ? {1'b0, len} : 7'd0);
    bus.in_ready = !reset && state == RUN && rem <= 7'd32;
    accept = bus.in_valid && bus.in_ready;
    nbytes = (!bus.in_last || bus.in_bytes == 6'd0) ? 6'd32 : bus.in_bytes;
    word = bus.in_data & ({DATA_WIDTH{1'b1}} >> {6'd32 - nbytes, 3'b0});
    for (int h = 0; h < 16; h++) payload[h*16 +: 16] = 5'(h) < pc ? mem[16 + h*16 +: 16] : 16'h0;
    done = state == DRAIN && (fill < 7'd2 || fill < {1'b0, len});
    mem_d = (mem >> {ext ? len : 6'd0, 3'b0}) | (accept ? {{DATA_WIDTH{1'b0}}, word} << {rem, 3'b0} : '0);
    fill_d = rem + (accept ? {1'b0, nbytes} : 7'd0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      mem <= '0;
      fill <= '0;
      trunc <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_tag <= '0;
      bus.out_data <= '0;
      bus.out_len <= '0;
    end else begin
      mem <= done ? '0 : mem_d;
      fill <= done ? 7'd0 : fill_d;
      trunc <= trunc | (done && fill != 7'd0);
      state <= done ? RUN : (accept && bus.in_last ? DRAIN : state);
      if (ext) begin
        bus.out_valid <= 1'b1;
        bus.out_tag <= tag;
        bus.out_data <= payload;
        bus.out_len <= LEN_WIDTH'(len);
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
    end
`ifdef UNALIGNER_STAT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) rec_count <= '0;
    else if (bus.out_valid && bus.out_ready) rec_count <= rec_count + 32'd1;
`endif
endmodule

// File: tb/tb_unaligner.sv
// tb_unaligner: random and directed record streams checked against a byte-queue reference model.
module tb_unaligner;
  typedef struct {
    logic [15:0] tag;
    logic [255:0] data;
    logic [7:0] len;
  } rec_t;
  logic clk = 1'b0;
  logic reset;
  logic trunc;
  unaligner_if bus();
`ifdef UNALIGNER_STAT_EN
  logic [31:0] rec_count;
  logic [31:0] cnt0;
`endif
  unaligner dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .trunc(trunc)
`ifdef UNALIGNER_STAT_EN
    ,
    .rec_count(rec_count)
`endif
  );
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  logic [7:0] sq[$];
  rec_t exp_q[$];
  bit exp_trunc = 1'b0;
  int first_out;
  int last_acc;
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  function automatic int popc(input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(t[i]);
    return n;
  endfunction
  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic add_rec(input logic [15:0] t, input logic [255:0] d);
    rec_t r;
    int n;
    n = popc(t);
    r.tag = t;
    r.len = 8'(2 + 2 * n);
    r.data = '0;
    sq.push_back(t[7:0]);
    sq.push_back(t[15:8]);
    for (int h = 0; h < n; h++) begin
      r.data[h*16 +: 16] = d[h*16 +: 16];
      sq.push_back(d[h*16 +: 8]);
      sq.push_back(d[h*16+8 +: 8]);
    end
    exp_q.push_back(r);
  endtask
  task automatic add_partial(input logic [15:0] t, input int k);
    for (int i = 0; i < k; i++) begin
      if (i == 0) sq.push_back(t[7:0]);
      else if (i == 1) sq.push_back(t[15:8]);
      else sq.push_back(8'($urandom));
    end
    exp_trunc = 1'b1;
  endtask
  task automatic run_stream(input int stall, input int rdy_pct, input int vld_pct);
    int n;
    int nw;
    int w;
    int cyc;
    int nrec;
    int last_take;
    bit held;
    logic [15:0] h_tag;
    logic [255:0] h_data;
    logic [7:0] h_len;
    rec_t r;
    n = sq.size();
    nw = (n + 31) / 32;
    w = 0;
    cyc = 0;
    held = 1'b0;
    nrec = exp_q.size();
    last_take = -1;
    first_out = -1;
    last_acc = -1;
    while ((w < nw || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      bus.in_valid = w < nw && $urandom_range(99) < 32'(vld_pct);
      for (int b = 0; b < 32; b++) begin
        if (w * 32 + b < n) bus.in_data[b*8 +: 8] = sq[w*32+b];
        else bus.in_data[b*8 +: 8] = 8'($urandom);
      end
      bus.in_last = w == nw - 1;
      bus.in_bytes = bus.in_last ? 6'(n - w * 32) : 6'($urandom);
      if (bus.in_last && n - w * 32 == 32 && $urandom_range(1) == 1) bus.in_bytes = 6'd0;
      bus.out_ready = cyc >= stall && $urandom_range(99) < 32'(rdy_pct);
      #1;
      if (held) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_tag", bus.out_tag, h_tag);
        check("hold_len", bus.out_len, h_len);
        check("hold_data", bus.out_data, h_data);
      end
      held = bus.out_valid && !bus.out_ready;
      h_tag = bus.out_tag;
      h_len = bus.out_len;
      h_data = bus.out_data;
      if (stall >= 6 && cyc == stall - 1) check("stall_in_ready", bus.in_ready, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (first_out < 0) first_out = cyc;
        last_take = cyc;
        check("rec_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          check("out_tag", bus.out_tag, r.tag);
          check("out_len", bus.out_len, r.len);
          check("out_data", bus.out_data, r.data);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        last_acc = cyc;
        w++;
      end
      cyc++;
    end
    check("timeout", cyc < 3000, 1);
    if (stall > 0) check("throughput", last_take - stall, nrec - 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("idle_out_valid", bus.out_valid, 0);
    end
    check("trunc", trunc, exp_trunc);
    check("back_to_run", bus.in_ready, 1);
    sq.delete();
    exp_q.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_trunc = 1'b0;
  endtask
  initial begin
    int nrec;
    int sel;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_bytes = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_len", bus.out_len, 0);
    check("rst_trunc", trunc, 0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    // single full record split over two words
    add_rec(16'hFFFF, 256'h4321_FEDC_BA98_7654_3210_FEDC_BA98_7654_3210_FEDC_BA98_7654_3210_0123_8765_4321);
    run_stream(0, 100, 100);
    check("latency", first_out, last_acc + 2);
    // 34 + 2 + 34 bytes
`ifdef UNALIGNER_STAT_EN
    cnt0 = rec_count;
`endif
    add_rec(16'hFFFF, rnd());
    add_rec(16'h0000, rnd());
    add_rec(16'hFFFF, rnd());
    run_stream(0, 100, 100);
`ifdef UNALIGNER_STAT_EN
    check("rec_count", rec_count - cnt0, 3);
`endif
    // consumer stall with back-pressure
    for (int i = 0; i < 4; i++) add_rec(16'hFFFF, rnd());
    run_stream(6, 100, 100);
    // reset in the middle of a record
    add_rec(16'hFFFF, rnd());
    @(negedge clk);
    for (int b = 0; b < 32; b++) bus.in_data[b*8 +: 8] = sq[b];
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_fill", dut.fill, 0);
    @(negedge clk);
    reset = 1'b0;
    sq.delete();
    exp_q.delete();
    add_rec(16'h8421, rnd());
    add_rec(16'hFFFF, rnd());
    run_stream(0, 80, 80);
    // truncated record: tag 0x0003 needs 6 bytes, only 3 arrive
    add_partial(16'h0003, 3);
    run_stream(0, 100, 100);
    do_reset();
    // randomized streams
    for (int s = 0; s < 24; s++) begin
      nrec = 1 + int'($urandom_range(5));
      for (int k = 0; k < nrec; k++) begin
        sel = int'($urandom_range(3));
        add_rec(sel == 0 ? 16'h0000 : sel == 1 ? 16'hFFFF : 16'($urandom), rnd());
      end
      if ($urandom_range(3) == 0) begin
        logic [15:0] t;
        t = 16'($urandom);
        add_partial(t, 1 + int'($urandom_range(32'(1 + 2 * popc(t)) - 1)));
      end
      run_stream(0, 40 + int'($urandom_range(60)), 40 + int'($urandom_range(60)));
      if (exp_trunc) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
